uart_rx: RTL

//   Serial UART receiver; counterpart of the team's uart_tx. Oversamples rx with the

---
 rtl/uart_rx_if.sv | 46 ++++
 rtl/uart_rx.sv | 139 +++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: bundles the serial line, the shared 16x baud tick and the
// received-word outputs of uart_rx.
// Optional frm_err signal is present only when UART_RX_FRAME_ERR_EN is defined.
interface uart_rx_if;
  logic       rx;
  logic       s_tick;
  logic       rx_done_tick;
  logic [7:0] dout;
`ifdef UART_RX_FRAME_ERR_EN
  logic       frm_err;

  // Receiver side: consumes line and tick, produces word, strobe and error flag
  modport master (
    input  rx,
    input  s_tick,
    output rx_done_tick,
    output dout,
    output frm_err
  );

  // Consumer side: drives line and tick, observes the received word
  modport slave (
    output rx,
    output s_tick,
    input  rx_done_tick,
    input  dout,
    input  frm_err
  );
`else
  // Receiver side: consumes line and tick, produces word and strobe
  modport master (
    input  rx,
    input  s_tick,
    output rx_done_tick,
    output dout
  );

  // Consumer side: drives line and tick, observes the received word
  modport slave (
    output rx,
    output s_tick,
    input  rx_done_tick,
    input  dout
  );
`endif
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver (1 start, DBIT data LSB first, stop).
// The received word is left-aligned in dout; rx_done_tick pulses for one clk
// when the frame completes, and dout takes the new word on that same edge.
// Optional feature: define UART_RX_FRAME_ERR_EN to add frm_err, which flags a
// low stop-bit sample alongside rx_done_tick.
module uart_rx #(
  parameter int DBIT    = 8,   // data bits per frame, 6..8
  parameter int SB_TICK = 16   // ticks in stop state: 16/24/32 = 1/1.5/2 stop bits
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.master bus
);

  // Tick counter must also cover 1.5/2 stop-bit settings, so widen past 4 bits if needed
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_BIT  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST = 3'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [SW-1:0] s_reg, s_next;
  logic [2:0]    n_reg, n_next;
  logic [7:0]    b_reg, b_next;
  logic [7:0]    dout_reg, dout_next;
  logic [1:0]    sync_reg;
  logic          rx_s;
  logic          done;

  // Two-flop synchroniser for the asynchronous serial line; idles high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], bus.rx};
    end
  end

  assign rx_s = sync_reg[1];

  // FSMD state, counters, shift register and output word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      dout_reg  <= '0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      dout_reg  <= dout_next;
    end
  end

  // Next-state logic: count ticks to the middle of each bit and sample there
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    dout_next  = dout_reg;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        // A tick on this clk is deliberately not counted; counting starts in START
        if (!rx_s) begin
          state_next = START;
          s_next     = '0;
          b_next     = '0;   // clearing here leaves unused low bits zero for DBIT<8
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (s_reg == S_MID) begin
            if (!rx_s) begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
            end else begin
              state_next = IDLE;   // line went back high: treat as a glitch
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (s_reg == S_BIT) begin
            s_next = '0;
            b_next = {rx_s, b_reg[7:1]};
            if (n_reg == N_LAST) begin
              state_next = STOP;
            end else begin
              n_next = n_reg + 1'b1;
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      STOP: begin
        if (bus.s_tick) begin
          if (s_reg == S_STOP) begin
            state_next = IDLE;
            done       = 1'b1;
            dout_next  = b_reg;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.rx_done_tick = done;
  assign bus.dout         = dout_reg;

`ifdef UART_RX_FRAME_ERR_EN
  // Stop-bit sample taken on the final stop tick; low means a framing error
  assign bus.frm_err = done & ~rx_s;
`endif

endmodule
